// File: rtl/dac_update_arbiter.sv
// Round-robin scheduler sharing one SPI DAC serializer among NCH sample producers.
// Captures the winning sample, drives enable/din, and follows each transfer through CS.
module dac_update_arbiter #(
    parameter int NCH     = 4,
    parameter int DW      = 12,
    parameter int MIN_GAP = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*DW-1:0]      data,
    output logic [NCH-1:0]         ack,
    output logic                   dac_enable,
    output logic [DW-1:0]          dac_din,
    output logic [$clog2(NCH)-1:0] dac_sel,
    input  logic                   dac_cs,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   err_sticky
);

    localparam int SW = $clog2(NCH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] GAP_LAST   = TW'(MIN_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        WAIT_DONE,
        GAP
    } state_t;

    // CS comes from the serializer's SCLK domain, so it is only used after two flops.
    logic cs_meta;
    logic cs_s;

    always_ff @(posedge clk or posedge reset) begin
        // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            cs_meta <= 1'b1;
            cs_s    <= 1'b1;
        end else begin
            cs_meta <= dac_cs;
            cs_s    <= cs_meta;
        end
    end

    logic [DW-1:0] chan_data [NCH];

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        assign chan_data[i] = data[i*DW +: DW];
    end

    state_t        state;
    state_t        state_nx;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nx;
    logic [TW-1:0] timer_inc;
    logic [SW-1:0] last;
    logic [SW-1:0] last_nx;
    logic [SW-1:0] winner;
    logic [SW-1:0] cand;
    logic          any_req;

    logic [NCH-1:0] ack_nx;
    logic           enable_nx;
    logic [DW-1:0]  din_nx;
    logic [SW-1:0]  sel_nx;
    logic           busy_nx;
    logic           done_nx;
    logic           err_nx;
    logic           sticky_nx;

    // Search starts just after the previous winner and wraps modulo NCH.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        winner  = last;
        cand    = last;
        any_req = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            cand = SW'((int'(last) + k) % NCH);
            if (req[cand] && !any_req) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

    assign timer_inc = (&timer) ? timer : timer + TW'(1);

    always_comb begin
        state_nx  = state;
        timer_nx  = timer_inc;
        last_nx   = last;
        ack_nx    = '0;
        enable_nx = dac_enable;
        din_nx    = dac_din;
        sel_nx    = dac_sel;
        busy_nx   = busy;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        sticky_nx = err_sticky;

        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nx  = WAIT_START;
                    timer_nx  = '0;
                    last_nx   = winner;
                    ack_nx    = NCH'(1) << winner;
                    enable_nx = 1'b1;
                    din_nx    = chan_data[winner];
                    sel_nx    = winner;
                    busy_nx   = 1'b1;
                end
            end

            // Enable is held until CS is seen low so a slow SCLK cannot miss it.
            WAIT_START: begin
                if (!cs_s) begin
                    enable_nx = 1'b0;
                    state_nx  = WAIT_DONE;
                    timer_nx  = '0;
                end else if (timer == TIMER_LAST) begin
                    enable_nx = 1'b0;
                    err_nx    = 1'b1;
                    sticky_nx = 1'b1;
                    state_nx  = GAP;
                    timer_nx  = '0;
                end
            end

            WAIT_DONE: begin
                if (cs_s) begin
                    done_nx  = 1'b1;
                    state_nx = GAP;
                    timer_nx = '0;
                end else if (timer == TIMER_LAST) begin
                    err_nx    = 1'b1;
                    sticky_nx = 1'b1;
                    state_nx  = GAP;
                    timer_nx  = '0;
                end
            end

            // The gap lets a just-acknowledged requester drop req before re-arbitration.
            GAP: begin
                if (timer == GAP_LAST) begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            end

            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            last       <= SW'(NCH - 1);
            ack        <= '0;
            dac_enable <= 1'b0;
            dac_din    <= '0;
            dac_sel    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_nx;
            timer      <= timer_nx;
            last       <= last_nx;
            ack        <= ack_nx;
            dac_enable <= enable_nx;
            dac_din    <= din_nx;
            dac_sel    <= sel_nx;
            busy       <= busy_nx;
            done       <= done_nx;
            err        <= err_nx;
            err_sticky <= sticky_nx;
        end
    end

endmodule

// File: tb/tb_dac_update_arbiter.sv
// Self-checking bench for dac_update_arbiter: a cycle-stepped serializer model and a
// rotating-queue round-robin reference drive and check randomized and directed transfers.
module tb_dac_update_arbiter;

    localparam int NCH     = 4;
    localparam int DW      = 12;
    localparam int MIN_GAP = 4;
    localparam int TIMEOUT = 4096;
    localparam int SW      = $clog2(NCH);

    logic              clk = 1'b0;
    logic              reset;
    logic [NCH-1:0]    req;
    logic [NCH*DW-1:0] data;
    logic [NCH-1:0]    ack;
    logic              dac_enable;
    logic [DW-1:0]     dac_din;
    logic [SW-1:0]     dac_sel;
    logic              dac_cs;
    logic              busy;
    logic              done;
    logic              err;
    logic              err_sticky;

    int checks = 0;
    int errors = 0;

    // Reference state: sample values held by each producer, and the priority order
    // as a queue whose head is the channel that wins next among those requesting.
    logic [DW-1:0] chan_val [NCH];
    int            rr_order [$];
    int            wait_cnt [NCH];
    logic [DW-1:0] exp_din;
    int            exp_sel;

    dac_update_arbiter #(
        .NCH     (NCH),
        .DW      (DW),
        .MIN_GAP (MIN_GAP),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .dac_enable (dac_enable),
        .dac_din    (dac_din),
        .dac_sel    (dac_sel),
        .dac_cs     (dac_cs),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_sticky (err_sticky)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        check("pulse_excl", {30'd0, done & err, $countones(ack) > 1}, 32'd0);
    endtask

    task automatic set_chan(input int ch, input logic [DW-1:0] v);
        chan_val[ch]       = v;
        data[ch*DW +: DW]  = v;
    endtask

    task automatic model_reset();
        rr_order = {};
        for (int i = 0; i < NCH; i++) begin
            rr_order.push_back(i);
            wait_cnt[i] = 0;
        end
    endtask

    function automatic int model_pick(input logic [NCH-1:0] r);
        int pick;
        pick = -1;
        for (int i = rr_order.size() - 1; i >= 0; i--) begin
            if (r[rr_order[i]]) pick = rr_order[i];
        end
        return pick;
    endfunction

    // After a grant the winner and everything ahead of it rotate to the back.
    task automatic model_commit(input int w);
        int c;
        c = rr_order.pop_front();
        rr_order.push_back(c);
        while (c != w) begin
            c = rr_order.pop_front();
            rr_order.push_back(c);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ack"}, 32'(ack), 32'd0);
        check({tag, "_enable"}, 32'(dac_enable), 32'd0);
        check({tag, "_din"}, 32'(dac_din), 32'd0);
        check({tag, "_sel"}, 32'(dac_sel), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_sticky"}, 32'(err_sticky), 32'd0);
    endtask

    // The DUT must be in IDLE at the next edge with req already driven.
    task automatic expect_grant(input string tag, output int w);
        logic [NCH-1:0] r;
        r = req;
        w = model_pick(r);
        step();
        check({tag, "_ack"}, 32'(ack), (w < 0) ? 32'd0 : (32'd1 << w));
        if (w >= 0) begin
            exp_din = chan_val[w];
            exp_sel = w;
            check({tag, "_din"}, 32'(dac_din), 32'(exp_din));
            check({tag, "_sel"}, 32'(dac_sel), 32'(exp_sel));
            check({tag, "_enable"}, 32'(dac_enable), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd1);
            for (int i = 0; i < NCH; i++) begin
                if (i == w || !r[i]) begin
                    wait_cnt[i] = 0;
                end else begin
                    wait_cnt[i]++;
                    check({tag, "_fair"}, 32'(wait_cnt[i] <= NCH - 1), 32'd1);
                end
            end
            model_commit(w);
            req[w] = 1'b0;
        end
    endtask

    // GAP phase: MIN_GAP edges with no pulses; busy falls on the last one.
    task automatic finish_gap(input string tag, input logic [NCH-1:0] gap_raise);
        for (int g = 1; g <= MIN_GAP; g++) begin
            if (g == MIN_GAP - 1) req = req | gap_raise;
            step();
            check({tag, "_gap_pulses"}, 32'({ack, done, err}), 32'd0);
            check({tag, "_gap_busy"}, 32'(busy), (g < MIN_GAP) ? 32'd1 : 32'd0);
        end
    endtask

    // Serializer model: CS falls start_dly cycles after the post-grant cycle and stays
    // low for low_len cycles. Each CS edge takes two sync flops plus one decision edge.
    task automatic serve(input string tag, input int start_dly, input int low_len,
                         input logic [NCH-1:0] reraise, input logic [NCH-1:0] gap_raise);
        step();
        check({tag, "_ack_width"}, 32'(ack), 32'd0);
        check({tag, "_en_hold"}, 32'(dac_enable), 32'd1);
        req = req | reraise;
        for (int i = 0; i < start_dly; i++) begin
            step();
            check({tag, "_en_wait"}, 32'(dac_enable), 32'd1);
        end
        dac_cs = 1'b0;
        step();
        step();
        check({tag, "_en_until_cs"}, 32'(dac_enable), 32'd1);
        step();
        check({tag, "_en_drop"}, 32'(dac_enable), 32'd0);
        check({tag, "_busy_low"}, 32'(busy), 32'd1);
        for (int i = 3; i < low_len; i++) begin
            step();
            check({tag, "_no_done"}, 32'({done, err}), 32'd0);
        end
        dac_cs = 1'b1;
        step();
        step();
        check({tag, "_done_early"}, 32'(done), 32'd0);
        step();
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd1);
        finish_gap(tag, gap_raise);
        check({tag, "_din_hold"}, 32'(dac_din), 32'(exp_din));
        check({tag, "_sel_hold"}, 32'(dac_sel), 32'(exp_sel));
    endtask

    initial begin
        int             w;
        int             hi;
        int             n;
        int             dones;
        logic [NCH-1:0] m;

        reset  = 1'b1;
        req    = '0;
        data   = '0;
        dac_cs = 1'b1;
        for (int i = 0; i < NCH; i++) chan_val[i] = '0;
        model_reset();
        step();
        step();
        check_reset("por");
        reset = 1'b0;

        // Single request on channel 2; channel 3 raises req two cycles before GAP ends.
        set_chan(2, 12'hA5C);
        set_chan(3, 12'h3C7);
        req = 4'b0100;
        expect_grant("single", w);
        check("single_ack_onehot", 32'(ack), 32'h4);
        check("single_din_value", 32'(dac_din), 32'hA5C);
        serve("single", 5, 12, '0, 4'b1000);
        expect_grant("gap_req", w);
        check("gap_req_ack", 32'(ack), 32'h8);
        serve("gap_req", 2, 6, '0, '0);

        // CS never falls: enable stays up TIMEOUT cycles, then one err pulse.
        set_chan(1, DW'($urandom));
        req = 4'b0010;
        expect_grant("stuck_hi", w);
        hi    = 1;
        dones = 0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            step();
            if (done) dones++;
            if (!dac_enable) break;
            hi++;
        end
        check("stuck_hi_en_cycles", hi, TIMEOUT);
        check("stuck_hi_err", 32'(err), 32'd1);
        check("stuck_hi_sticky", 32'(err_sticky), 32'd1);
        check("stuck_hi_no_done", dones, 0);
        finish_gap("stuck_hi", '0);

        set_chan(0, DW'($urandom));
        req = 4'b0001;
        expect_grant("after_err", w);
        serve("after_err", 1, 5, '0, '0);
        check("after_err_sticky", 32'(err_sticky), 32'd1);

        // CS falls then sticks low: abort TIMEOUT cycles into WAIT_DONE.
        set_chan(3, DW'($urandom));
        req = 4'b1000;
        expect_grant("stuck_lo", w);
        step();
        dac_cs = 1'b0;
        step();
        step();
        step();
        check("stuck_lo_en_drop", 32'(dac_enable), 32'd0);
        n     = 0;
        dones = 0;
        for (int i = 0; i < TIMEOUT + 8; i++) begin
            step();
            n++;
            if (done) dones++;
            if (err) break;
        end
        check("stuck_lo_wait", n, TIMEOUT);
        check("stuck_lo_err", 32'(err), 32'd1);
        check("stuck_lo_no_done", dones, 0);
        dac_cs = 1'b1;
        finish_gap("stuck_lo", '0);

        // Asynchronous reset in the middle of WAIT_DONE, checked before any clock edge.
        set_chan(0, DW'($urandom));
        req = 4'b0001;
        expect_grant("rst", w);
        step();
        dac_cs = 1'b0;
        repeat (6) step();
        check("rst_pre_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset("async_rst");
        dac_cs = 1'b1;
        req    = '0;
        step();
        step();
        reset = 1'b0;
        model_reset();

        // All four requesting continuously, each re-raising right after its ack.
        for (int i = 0; i < NCH; i++) set_chan(i, DW'(12'h100 * i + 1));
        req = '1;
        for (int t = 0; t < 6; t++) begin
            expect_grant("rr", w);
            check("rr_order_ack", 32'(ack), 32'd1 << (t % NCH));
            check("rr_order_din", 32'(dac_din), 32'h100 * (t % NCH) + 1);
            m    = '0;
            m[w] = 1'b1;
            serve("rr", $urandom_range(0, 4), $urandom_range(3, 10), m, '0);
        end

        // Random mixes of pending requests; pending channels keep their data stable.
        req = '0;
        for (int t = 0; t < 30; t++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!req[i]) set_chan(i, DW'($urandom));
            end
            req = req | NCH'($urandom);
            if (req == '0) req[$urandom_range(0, NCH - 1)] = 1'b1;
            expect_grant("rand", w);
            serve("rand", $urandom_range(0, 6), $urandom_range(3, 16), '0, '0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
